// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the ARM-subset core
// Purpose: common widths, reset PC default, R15 read offset and next-pc select type.
package core_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] R15_OFFSET       = 32'd8;

    // Next-pc source selected by the fetch control logic.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_TGT  = 2'd2
    } pc_sel_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with hold / +4 / target mux
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_sel        : next-pc source (hold, increment, aligned target)
//   i_target_w   : word address of redirect target (byte address bits [31:2])
//   o_pc         : current byte address, bits [1:0] always zero
module fetch_pc_reg
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  pc_sel_e     i_sel,
    input  logic [29:0] i_target_w,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_INC:  w_pc_next = r_pc + WORD_BYTES;   // wraps modulo 2^32
            PC_TGT:  w_pc_next = {i_target_w, 2'b00};
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID output register
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   imem_addr/imem_data : instruction memory address out, combinational data in
//   halt                : inhibit new fetches (held output still drains)
//   br_taken/br_target  : redirect request from execute
//   instr/instr_pc      : registered instruction and its byte address
//   pc_plus8            : instr_pc + 8 (R15 read value)
//   instr_valid/ready   : handshake to decode
//   misalign            : one-cycle pulse when a redirect target was unaligned
//   accept_cnt          : wrapping count of completed handshakes
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DATA_W   = INSTR_W,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic [DATA_W-1:0] instr,
    output logic [31:0]       instr_pc,
    output logic [31:0]       pc_plus8,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              misalign,
    output logic [CNT_W-1:0]  accept_cnt
);
    logic [DATA_W-1:0] r_instr;
    logic [31:0]       r_instr_pc;
    logic              r_valid;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_accept_cnt;

    logic              w_fire;
    logic              w_accept;
    logic [31:0]       w_pc;
    pc_sel_e           w_pc_sel;

    // A fetch needs a free (or freeing) output slot and no redirect/halt.
    assign w_fire   = !br_taken && !halt && (!r_valid || instr_ready);
    assign w_accept = r_valid && instr_ready;

    always_comb begin
        w_pc_sel = PC_HOLD;
        if (br_taken) begin
            w_pc_sel = PC_TGT;
        end else if (w_fire) begin
            w_pc_sel = PC_INC;
        end
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .i_sel      (w_pc_sel),
        .i_target_w (br_target[31:2]),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_valid      <= 1'b0;
            r_misalign   <= 1'b0;
            r_accept_cnt <= '0;
        end else begin
            r_misalign <= br_taken && (br_target[1:0] != 2'b00);
            // Counted even when a redirect flushes the slot in the same cycle.
            if (w_accept) begin
                r_accept_cnt <= r_accept_cnt + CNT_W'(1);
            end
            if (br_taken) begin
                r_valid <= 1'b0;
            end else if (w_fire) begin
                r_instr    <= imem_data;
                r_instr_pc <= w_pc;
                r_valid    <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = w_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign pc_plus8    = r_instr_pc + R15_OFFSET;
    assign instr_valid = r_valid;
    assign misalign    = r_misalign;
    assign accept_cnt  = r_accept_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: default parameters
    logic        reset, halt, br_taken, instr_ready;
    logic [31:0] br_target, imem_addr, imem_data, instr, instr_pc, pc_plus8;
    logic        instr_valid, misalign;
    logic [15:0] accept_cnt;

    // DUT 2: wrap-around reset PC and narrow counter
    logic        reset2, ready2;
    logic [31:0] imem_addr2, imem_data2, instr2, instr_pc2, pc_plus8_2;
    logic        valid2, misalign2;
    logic [3:0]  accept_cnt2;

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        mem = (a == 32'd0) ? 32'hE290_0016 : {16'hA5A5, a[15:0]};
    endfunction

    assign imem_data  = mem(imem_addr);
    assign imem_data2 = mem(imem_addr2);

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .halt(halt), .br_taken(br_taken), .br_target(br_target),
        .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .misalign(misalign), .accept_cnt(accept_cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DATA_W(32), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .halt(1'b0), .br_taken(1'b0), .br_target(32'd0),
        .instr(instr2), .instr_pc(instr_pc2), .pc_plus8(pc_plus8_2),
        .instr_valid(valid2), .instr_ready(ready2),
        .misalign(misalign2), .accept_cnt(accept_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; br_taken = 1'b0; br_target = 32'd0; instr_ready = 1'b0;
        reset2 = 1'b1; ready2 = 1'b1;
        step(); step();
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mis",   {31'd0, misalign}, 32'd0);
        chk("rst_cnt",   {16'd0, accept_cnt}, 32'd0);

        // 1: first capture one edge after release
        reset = 1'b0;
        step();
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'hE290_0016);
        chk("t1_pc",    instr_pc, 32'd0);
        chk("t1_p8",    pc_plus8, 32'd8);
        chk("t1_addr",  imem_addr, 32'd4);

        // 2: full throughput for 8 cycles
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_pc", instr_pc, 32'(4 * k));
            step();
        end
        chk("t2_cnt",   {16'd0, accept_cnt}, 32'd8);
        chk("t2_pc20",  instr_pc, 32'h20);
        chk("t2_instr", instr, 32'hA5A5_0020);

        // back to pc 8 via aligned redirect (flushes 0x20, which still counts)
        br_taken = 1'b1; br_target = 32'h8;
        step();
        chk("rd_valid", {31'd0, instr_valid}, 32'd0);
        chk("rd_mis",   {31'd0, misalign}, 32'd0);
        chk("rd_addr",  imem_addr, 32'h8);
        chk("rd_cnt",   {16'd0, accept_cnt}, 32'd9);
        br_taken = 1'b0; instr_ready = 1'b0;
        step();
        chk("t3_pc8", instr_pc, 32'h8);

        // 3: back-pressure for 3 cycles
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_hold_pc",    instr_pc, 32'h8);
            chk("t3_hold_instr", instr, 32'hA5A5_0008);
            chk("t3_hold_addr",  imem_addr, 32'hC);
            chk("t3_hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        chk("t3_cnt", {16'd0, accept_cnt}, 32'd9);
        instr_ready = 1'b1;
        step();
        chk("t3_next_pc", instr_pc, 32'hC);
        chk("t3_next_cnt", {16'd0, accept_cnt}, 32'd10);

        // 4: misaligned redirect while stalled
        instr_ready = 1'b0;
        br_taken = 1'b1; br_target = 32'h16;
        step();
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_addr",  imem_addr, 32'h14);
        chk("t4_mis",   {31'd0, misalign}, 32'd1);
        chk("t4_cnt",   {16'd0, accept_cnt}, 32'd10);
        br_taken = 1'b0; br_target = 32'd0;
        step();
        chk("t4_pc",     instr_pc, 32'h14);
        chk("t4_mis0",   {31'd0, misalign}, 32'd0);
        chk("t4_valid1", {31'd0, instr_valid}, 32'd1);
        chk("t4_addr2",  imem_addr, 32'h18);

        // 5: halt drains, pc frozen; reset mid-stall
        halt = 1'b1; instr_ready = 1'b1;
        step();
        chk("t5_drain", {31'd0, instr_valid}, 32'd0);
        chk("t5_cnt",   {16'd0, accept_cnt}, 32'd11);
        chk("t5_addr",  imem_addr, 32'h18);
        step();
        chk("t5_frozen", imem_addr, 32'h18);
        chk("t5_still",  {31'd0, instr_valid}, 32'd0);
        reset = 1'b1;
        step();
        chk("t5_rst_addr", imem_addr, 32'd0);
        chk("t5_rst_cnt",  {16'd0, accept_cnt}, 32'd0);
        reset = 1'b0;
        step();
        chk("t5_halt_valid", {31'd0, instr_valid}, 32'd0);
        // halt and redirect together: redirect wins, fetch stays inhibited
        br_taken = 1'b1; br_target = 32'h40;
        step();
        chk("t5_hb_addr", imem_addr, 32'h40);
        br_taken = 1'b0;
        step();
        chk("t5_hb_hold",  imem_addr, 32'h40);
        chk("t5_hb_valid", {31'd0, instr_valid}, 32'd0);
        halt = 1'b0;
        step();
        chk("t5_resume_pc",    instr_pc, 32'h40);
        chk("t5_resume_instr", instr, 32'hA5A5_0040);

        // 6: pc wrap and counter wrap on the second instance
        reset2 = 1'b0;
        step();
        chk("t6_pc0", instr_pc2, 32'hFFFF_FFF8);
        chk("t6_p8",  pc_plus8_2, 32'h0000_0000);
        step();
        chk("t6_pc1", instr_pc2, 32'hFFFF_FFFC);
        step();
        chk("t6_pc2",   instr_pc2, 32'h0000_0000);
        chk("t6_instr", instr2, 32'hE290_0016);
        for (int k = 0; k < 15; k++) step();
        chk("t6_cnt_wrap", {28'd0, accept_cnt2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
